// File: rtl/note_scheduler_pkg.sv
// Shared encodings for the rhythm-game note path: mode controller codes,
// difficulty codes and the scheduler FSM states.
// Imported by note_scheduler, beat_timer and the mode controller.
package note_scheduler_pkg;

  localparam logic [2:0] MODE_IDLE   = 3'd1;
  localparam logic [2:0] MODE_EDIT   = 3'd2;
  localparam logic [2:0] MODE_DIFF   = 3'd3;
  localparam logic [2:0] MODE_RUN    = 3'd4;
  localparam logic [2:0] MODE_PAUSE  = 3'd5;
  localparam logic [2:0] MODE_FINISH = 3'd6;

  // Code 3 is also treated as hard.
  localparam logic [1:0] DIFF_EASY = 2'd0;
  localparam logic [1:0] DIFF_MED  = 2'd1;
  localparam logic [1:0] DIFF_HARD = 2'd2;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FETCH = 2'd2,
    ST_SHIFT = 2'd3
  } state_e;

  // Modes outside RUN/PAUSE/FINISH (including illegal codes) wipe the song state.
  function automatic logic mode_clears(input logic [2:0] m);
    case (m)
      MODE_RUN, MODE_PAUSE, MODE_FINISH: return 1'b0;
      MODE_IDLE, MODE_EDIT, MODE_DIFF:   return 1'b1;
      default:                           return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/note_scheduler_beat_timer.sv
// Purpose: 24-bit beat counter; period chosen by the latched difficulty.
// Latency: beat is combinational from the counter, high in the last count of a period.
// Backpressure: none; counting stops whenever enable is low, clear forces 0.
// Ports: clk, n_rst; enable (count this cycle), clear (sync zero),
//        period_sel (difficulty code); beat (one-cycle pulse on wrap).
module beat_timer
  import note_scheduler_pkg::*;
#(
  parameter int BEAT_EASY = 6000000,
  parameter int BEAT_MED  = 4000000,
  parameter int BEAT_HARD = 2000000
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       enable,
  input  logic       clear,
  input  logic [1:0] period_sel,
  output logic       beat
);

  logic [23:0] cnt_q, cnt_d;
  logic [23:0] last_cnt;

  always_comb begin
    case (period_sel)
      DIFF_EASY: last_cnt = 24'(BEAT_EASY - 1);
      DIFF_MED:  last_cnt = 24'(BEAT_MED - 1);
      DIFF_HARD: last_cnt = 24'(BEAT_HARD - 1);
      default:   last_cnt = 24'(BEAT_HARD - 1);
    endcase
  end

  assign beat = enable && (cnt_q == last_cnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = beat ? '0 : cnt_q + 24'd1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/note_scheduler.sv
// Purpose: per-beat fetch of a song lane pattern and shift of a 4-row note display.
// Latency: beat -> mem_rd next cycle -> row3 loaded the cycle after (beat period + 2 per row).
// Backpressure: PAUSE freezes only in WAIT; FINISH freezes everything; setup modes clear.
// Ports: clk, n_rst; mode (game mode), diff (difficulty, taken in DIFF);
//        mem_rd/mem_addr/mem_data (pattern memory, 1-cycle read); rows (row0 = [3:0]),
//        beat, note_count (rows shifted out), song_done.
module note_scheduler
  import note_scheduler_pkg::*;
#(
  parameter int BEAT_EASY = 6000000,
  parameter int BEAT_MED  = 4000000,
  parameter int BEAT_HARD = 2000000,
  parameter int SONG_LEN  = 41
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [2:0]  mode,
  input  logic [1:0]  diff,
  output logic        mem_rd,
  output logic [5:0]  mem_addr,
  input  logic [3:0]  mem_data,
  output logic [15:0] rows,
  output logic        beat,
  output logic [5:0]  note_count,
  output logic        song_done
);

  localparam logic [5:0] LEN = 6'(SONG_LEN);

  state_e      state_q, state_d;
  logic [1:0]  diff_q;
  logic [5:0]  ptr_q;
  logic [15:0] rows_q;
  logic [5:0]  nc_q;
  logic        fvld_q;   // the FETCH just done issued a real read
  logic        clr;
  logic        frz;

  assign clr = mode_clears(mode);
  assign frz = (mode == MODE_FINISH);

  beat_timer #(
    .BEAT_EASY (BEAT_EASY),
    .BEAT_MED  (BEAT_MED),
    .BEAT_HARD (BEAT_HARD)
  ) u_beat_timer (
    .clk        (clk),
    .n_rst      (n_rst),
    .enable     ((state_q == ST_WAIT) && (mode == MODE_RUN)),
    .clear      (clr),
    .period_sel (diff_q),
    .beat       (beat)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= ST_CLEAR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_CLEAR;
    end else if (!frz) begin
      case (state_q)
        ST_CLEAR: if (mode == MODE_RUN) state_d = ST_WAIT;
        ST_WAIT:  if (beat) state_d = ST_FETCH;
        ST_FETCH: state_d = ST_SHIFT;
        ST_SHIFT: state_d = ST_WAIT;
        default:  state_d = ST_CLEAR;
      endcase
    end
  end

  // Past the end of the song no read is issued; SHIFT then feeds blank rows.
  always_comb begin
    mem_rd   = (state_q == ST_FETCH) && !clr && !frz && (ptr_q < LEN);
    mem_addr = ptr_q;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      diff_q <= DIFF_EASY;
      ptr_q  <= '0;
      rows_q <= '0;
      nc_q   <= '0;
      fvld_q <= 1'b0;
    end else begin
      if (mode == MODE_DIFF) diff_q <= diff;
      if (clr) begin
        ptr_q  <= '0;
        rows_q <= '0;
        nc_q   <= '0;
        fvld_q <= 1'b0;
      end else if (!frz) begin
        case (state_q)
          ST_FETCH: begin
            fvld_q <= mem_rd;
            if (mem_rd) ptr_q <= ptr_q + 6'd1;
          end
          ST_SHIFT: begin
            rows_q <= {(fvld_q ? mem_data : 4'b0), rows_q[15:4]};
            if (nc_q < LEN) nc_q <= nc_q + 6'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign rows       = rows_q;
  assign note_count = nc_q;
  assign song_done  = (nc_q == LEN);

endmodule

// File: doc/note_scheduler.md
NOTE_SCHEDULER -- requirements
Module: note_scheduler

Interface
REQ-001 SHALL have parameter BEAT_EASY, default 6000000, meaning clock cycles per beat at difficulty 0.
REQ-002 SHALL have parameter BEAT_MED, default 4000000, meaning clock cycles per beat at difficulty 1.
REQ-003 SHALL have parameter BEAT_HARD, default 2000000, meaning clock cycles per beat at difficulty 2 or 3.
REQ-004 SHALL have parameter SONG_LEN, default 41, meaning the number of song notes and the note_count saturation value.
REQ-005 SHALL have port clk, input, 1 bit: the single system clock.
REQ-006 SHALL have port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port mode, input, 3 bits: game mode (IDLE=1, EDIT=2, DIFF=3, RUN=4, PAUSE=5, FINISH=6).
REQ-008 SHALL have port diff, input, 2 bits: difficulty select, sampled only while mode==DIFF.
REQ-009 SHALL have port mem_rd, output, 1 bit: one-cycle read strobe to the song pattern memory.
REQ-010 SHALL have port mem_addr, output, 6 bits: pattern memory address, valid while mem_rd is high.
REQ-011 SHALL have port mem_data, input, 4 bits: lane pattern, valid exactly one cycle after mem_rd.
REQ-012 SHALL have port rows, output, 16 bits: four rows of 4 lanes each; bits [3:0] are the hit row (row0) and bits [15:12] are the entry row (row3).
REQ-013 SHALL have port beat, output, 1 bit: one-cycle pulse on every beat.
REQ-014 SHALL have port note_count, output, 6 bits: number of rows shifted out of row0, fed to the mode controller.
REQ-015 SHALL have port song_done, output, 1 bit: high while note_count==SONG_LEN.

Function
REQ-016 SHALL latch diff into a 2-bit difficulty register on every cycle in which mode==DIFF; all other modes hold the register.
REQ-017 SHALL select the beat period from the latched difficulty: 0 gives BEAT_EASY, 1 gives BEAT_MED, and 2 or 3 give BEAT_HARD.
REQ-018 SHALL implement a 24-bit beat counter that counts only in states WAIT and mode==RUN; on reaching period-1 it SHALL pulse beat for one cycle, wrap to 0, and move to FETCH.
REQ-019 SHALL implement FSM states CLEAR, WAIT, FETCH and SHIFT.
REQ-020 SHALL transition CLEAR->WAIT when mode==RUN.
REQ-021 SHALL transition WAIT->FETCH on beat.
REQ-022 SHALL transition FETCH->SHIFT unconditionally.
REQ-023 SHALL transition SHIFT->WAIT unconditionally.
REQ-024 SHALL, in FETCH, assert mem_rd for one cycle with mem_addr = fetch pointer when the fetch pointer < SONG_LEN, and then increment the fetch pointer; when the fetch pointer >= SONG_LEN it SHALL NOT assert mem_rd and SHALL supply 4'b0 as the data.
REQ-025 SHALL, in SHIFT, set row0<=row1, row1<=row2, row2<=row3, and row3<=mem_data (or 0 per REQ-024), and increment note_count, saturating at SONG_LEN.
REQ-026 SHALL, while mode==PAUSE, freeze the beat counter, rows, pointer and note_count in WAIT; a FETCH or SHIFT already started SHALL complete, because data is in flight.
REQ-027 SHALL, while mode==FINISH, freeze all state and outputs, with beat and mem_rd held low.
REQ-028 SHALL, when mode is IDLE, EDIT, DIFF or any illegal value, synchronously return to CLEAR with the counter, pointer, rows and note_count at 0, overriding any beat in the same cycle.
REQ-029 SHALL have beat and mem_rd high for at most one cycle each per beat, and SHALL NOT assert them in CLEAR.

Reset
REQ-030 SHALL, on n_rst low, asynchronously set state=CLEAR, difficulty=0, counter=0, fetch pointer=0, rows=0, note_count=0, beat=0 and mem_rd=0; song_done is 0.
REQ-031 SHALL, on reset mid-beat, discard any in-flight fetch, and the first beat after reset SHALL occur a full period after mode==RUN.

Structure
REQ-032 SHALL place the mode encodings (IDLE..FINISH), the difficulty encodings and the FSM state enum in a shared package, which is also imported by the mode controller.
REQ-033 SHALL implement the beat counter and period select as a sub-module named beat_timer (inputs: enable, clear, period select; output: beat); the FSM, fetch logic and row shifter SHALL live in note_scheduler.

Verification
Scenarios use BEAT_EASY=8, BEAT_MED=6, BEAT_HARD=4 and SONG_LEN=5, with memory returning addr+1.
REQ-034 SHALL cover: diff=2 in DIFF, then RUN -> beat every 4+2 cycles of state; mem_addr sequence 0,1,2,3,4; rows[15:12] sequence 1,2,3,4,5.
REQ-035 SHALL cover: 5 shifts, then further beats -> mem_rd stays low, 0 enters row3, note_count holds at 5 and song_done=1.
REQ-036 SHALL cover: PAUSE asserted in the cycle of beat -> FETCH and SHIFT complete (one shift), then the counter freezes; on return to RUN the count resumes from the frozen value.
REQ-037 SHALL cover: mode->IDLE mid-song -> next cycle rows=0, note_count=0, mem_addr restarts at 0 on the next RUN.
REQ-038 SHALL cover: diff changed while in RUN -> period unchanged; FINISH -> all outputs frozen, beat=0.
REQ-039 SHALL cover: n_rst pulsed low asynchronously during FETCH -> all outputs 0 immediately, with no late shift.
